// File: rtl/processor_sequencer.sv
// ---------------------------------------------------------------------------
// processor_sequencer
//
// Multi-cycle control FSM for the simple 32-bit processor datapath. It owns
// the program counter and the instruction register. It sequences
// fetch / decode / execute over a single-port 4096x32 memory with
// synchronous reads. It also drives the register-file, PSR and memory
// strobes, and resolves branch conditions against the PSR.
//
// Parameters
//   START_PC    PC value loaded on reset
//   CNT_W       width of the retired-instruction counter (wraps)
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   run         level; sampled in IDLE only, 1 starts execution
//   mem_rdata   memory read data, valid the cycle after mem_rd
//   psr         {zero,negative,even,parity,carry}
//   mem_addr    memory address (meaningful while mem_rd or mem_wr is high)
//   mem_rd      memory read strobe
//   mem_wr      memory write strobe (write data comes from the datapath)
//   ir          instruction register
//   pc          program counter (address of next fetch)
//   reg_wr      register-file write strobe, index ir[3:0]
//   reg_wr_sel  writeback source: 0 = ALU result, 1 = mem_rdata
//   psr_wr      PSR update strobe
//   alu_op      ALU operation, equal to ir[31:28]
//   halted      high while in HALT
//   illegal     sticky flag, set when an opcode 4'hA..4'hF is decoded
//   retired     count of completed instructions
//
// All strobes and status outputs are registered. They are computed from
// the next state, next IR and next PC. The values seen during a cycle are
// therefore a pure function of the state and IR held in that cycle.
// ---------------------------------------------------------------------------
module processor_sequencer #(
   parameter logic [11:0] START_PC = 12'h100,
   parameter int          CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run,
   input  logic [31:0]      mem_rdata,
   input  logic [4:0]       psr,
   output logic [11:0]      mem_addr,
   output logic             mem_rd,
   output logic             mem_wr,
   output logic [31:0]      ir,
   output logic [11:0]      pc,
   output logic             reg_wr,
   output logic             reg_wr_sel,
   output logic             psr_wr,
   output logic [3:0]       alu_op,
   output logic             halted,
   output logic             illegal,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_MEMRD,
      S_WB,
      S_MEMWR,
      S_EXEC,
      S_HALT
   } state_t;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_LD  = 4'h1;
   localparam logic [3:0] OP_STR = 4'h2;
   localparam logic [3:0] OP_BRA = 4'h3;
   localparam logic [3:0] OP_XOR = 4'h4;
   localparam logic [3:0] OP_ADD = 4'h5;
   localparam logic [3:0] OP_ROT = 4'h6;
   localparam logic [3:0] OP_SHF = 4'h7;
   localparam logic [3:0] OP_HLT = 4'h8;
   localparam logic [3:0] OP_CMP = 4'h9;

   state_t        state;
   state_t        state_nxt;
   logic [31:0]   ir_nxt;
   logic [11:0]   pc_nxt;
   logic          retire;
   logic          illegal_set;

   logic [11:0]   addr_d;
   logic          mem_rd_d;
   logic          mem_wr_d;
   logic          reg_wr_d;
   logic          reg_wr_sel_d;
   logic          psr_wr_d;
   logic          halted_d;

   // Branch condition evaluation.
   // psr bit map: [4]=zero [3]=negative [2]=even [1]=parity [0]=carry.
   function automatic logic branch_taken(input logic [3:0] cc, input logic [4:0] flags);
      logic taken;
      case (cc)
         4'h0:    taken = 1'b1;
         4'h1:    taken = flags[1];
         4'h2:    taken = flags[2];
         4'h3:    taken = flags[0];
         4'h4:    taken = flags[3];
         4'h5:    taken = flags[4];
         4'h6:    taken = ~flags[0];
         4'h7:    taken = ~flags[3];
         default: taken = 1'b0;
      endcase
      return taken;
   endfunction

   assign alu_op = ir[31:28];

   // Next-state, next-PC and next-IR logic.
   always_comb begin
      state_nxt   = state;
      ir_nxt      = ir;
      pc_nxt      = pc;
      retire      = 1'b0;
      illegal_set = 1'b0;
      case (state)
         S_IDLE: begin
            if (run) state_nxt = S_FETCH;
         end
         S_FETCH: begin
            state_nxt = S_DECODE;
         end
         S_DECODE: begin
            // The instruction fetched last cycle is on mem_rdata now.
            ir_nxt = mem_rdata;
            pc_nxt = pc + 12'd1;
            case (mem_rdata[31:28])
               OP_NOP: begin
                  state_nxt = S_FETCH;
                  retire    = 1'b1;
               end
               OP_LD:  state_nxt = S_MEMRD;
               OP_STR: state_nxt = S_MEMWR;
               OP_BRA, OP_XOR, OP_ADD, OP_ROT, OP_SHF, OP_CMP:
                  state_nxt = S_EXEC;
               OP_HLT: state_nxt = S_HALT;
               default: begin
                  state_nxt   = S_HALT;
                  illegal_set = 1'b1;
               end
            endcase
         end
         S_MEMRD: begin
            state_nxt = S_WB;
         end
         S_WB: begin
            state_nxt = S_FETCH;
            retire    = 1'b1;
         end
         S_MEMWR: begin
            state_nxt = S_FETCH;
            retire    = 1'b1;
         end
         S_EXEC: begin
            state_nxt = S_FETCH;
            retire    = 1'b1;
            if (ir[31:28] == OP_BRA && branch_taken(ir[27:24], psr))
               pc_nxt = ir[11:0];
         end
         S_HALT: begin
            state_nxt = S_HALT;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Output decode for the state being entered, so that the registered
   // outputs line up with the state they belong to.
   always_comb begin
      addr_d       = pc_nxt;
      mem_rd_d     = 1'b0;
      mem_wr_d     = 1'b0;
      reg_wr_d     = 1'b0;
      reg_wr_sel_d = 1'b0;
      psr_wr_d     = 1'b0;
      halted_d     = 1'b0;
      case (state_nxt)
         S_FETCH: begin
            mem_rd_d = 1'b1;
         end
         S_MEMRD: begin
            mem_rd_d = 1'b1;
            addr_d   = ir_nxt[23:12];
         end
         S_WB: begin
            reg_wr_d     = 1'b1;
            reg_wr_sel_d = 1'b1;
            psr_wr_d     = 1'b1;
         end
         S_MEMWR: begin
            mem_wr_d = 1'b1;
            addr_d   = ir_nxt[11:0];
         end
         S_EXEC: begin
            // Branches produce no strobes; CMP updates flags only.
            if (ir_nxt[31:28] != OP_BRA) begin
               psr_wr_d = 1'b1;
               reg_wr_d = (ir_nxt[31:28] != OP_CMP);
            end
         end
         S_HALT: begin
            halted_d = 1'b1;
         end
         default: begin
            halted_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         pc         <= START_PC;
         ir         <= '0;
         retired    <= '0;
         illegal    <= 1'b0;
         mem_addr   <= START_PC;
         mem_rd     <= 1'b0;
         mem_wr     <= 1'b0;
         reg_wr     <= 1'b0;
         reg_wr_sel <= 1'b0;
         psr_wr     <= 1'b0;
         halted     <= 1'b0;
      end else begin
         state      <= state_nxt;
         pc         <= pc_nxt;
         ir         <= ir_nxt;
         if (retire)
            retired <= retired + CNT_W'(1);
         if (illegal_set)
            illegal <= 1'b1;
         mem_addr   <= addr_d;
         mem_rd     <= mem_rd_d;
         mem_wr     <= mem_wr_d;
         reg_wr     <= reg_wr_d;
         reg_wr_sel <= reg_wr_sel_d;
         psr_wr     <= psr_wr_d;
         halted     <= halted_d;
      end
   end

endmodule

// File: tb/tb_processor_sequencer.sv
// ---------------------------------------------------------------------------
// tb_processor_sequencer
//
// Drives processor_sequencer from a bench-side 4096x32 synchronous-read
// memory. An instruction-level reference model expands each instruction
// into the cycles it must occupy. A single compare loop checks every
// output on every cycle. Directed programs pin the model with literal
// expectations, and random programs cover the rest.
// ---------------------------------------------------------------------------
module tb_processor_sequencer;

   localparam logic [11:0] START = 12'h100;
   localparam int          MAXC  = 256;

   typedef struct packed {
      logic        rd;
      logic        wr;
      logic [11:0] addr;
      logic        rw;
      logic        sel;
      logic        pw;
      logic        h;
      logic        ill;
      logic [15:0] ret;
      logic [11:0] pc;
      logic [31:0] ir;
   } rec_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        run = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic [4:0]  psr = '0;
   logic [11:0] mem_addr;
   logic        mem_rd;
   logic        mem_wr;
   logic [31:0] ir;
   logic [11:0] pc;
   logic        reg_wr;
   logic        reg_wr_sel;
   logic        psr_wr;
   logic [3:0]  alu_op;
   logic        halted;
   logic        illegal;
   logic [15:0] retired;

   logic [31:0] mem [0:4095];
   rec_t        exp_q[$];
   rec_t        cap [0:MAXC-1];
   int          n_chk = 0;
   int          n_pass = 0;

   processor_sequencer dut (
      .clk(clk), .reset(reset), .run(run), .mem_rdata(mem_rdata), .psr(psr),
      .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .ir(ir), .pc(pc),
      .reg_wr(reg_wr), .reg_wr_sel(reg_wr_sel), .psr_wr(psr_wr), .alu_op(alu_op),
      .halted(halted), .illegal(illegal), .retired(retired)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_rd) mem_rdata <= mem[mem_addr];
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_chk++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got %h, expected %h", nm, act, expv);
   endtask

   function automatic logic taken(input logic [3:0] cc, input logic [4:0] p);
      logic zero, neg, even, par, carry;
      zero = p[4]; neg = p[3]; even = p[2]; par = p[1]; carry = p[0];
      if (cc == 4'h0) return 1'b1;
      if (cc == 4'h1) return par;
      if (cc == 4'h2) return even;
      if (cc == 4'h3) return carry;
      if (cc == 4'h4) return neg;
      if (cc == 4'h5) return zero;
      if (cc == 4'h6) return !carry;
      if (cc == 4'h7) return !neg;
      return 1'b0;
   endfunction

   task automatic push(input logic rd, input logic wr, input logic [11:0] addr,
                       input logic rw, input logic sel, input logic pw, input logic h,
                       input logic ill, input logic [15:0] ret, input logic [11:0] pcv,
                       input logic [31:0] irv);
      rec_t r;
      r.rd = rd; r.wr = wr; r.addr = addr; r.rw = rw; r.sel = sel; r.pw = pw;
      r.h = h; r.ill = ill; r.ret = ret; r.pc = pcv; r.ir = irv;
      if (exp_q.size() < MAXC) exp_q.push_back(r);
   endtask

   // Instruction-level model: one loop iteration per executed instruction,
   // emitting the per-cycle output records that instruction occupies.
   task automatic build_model(input logic [4:0] p, input int n);
      logic [11:0] pcm;
      logic [31:0] irm;
      logic [31:0] ins;
      logic [15:0] rm;
      logic        ilm;
      logic [3:0]  op;
      exp_q.delete();
      pcm = START; irm = '0; rm = '0; ilm = 1'b0;
      push(0, 0, 0, 0, 0, 0, 0, ilm, rm, pcm, irm);                 // idle
      while (exp_q.size() < n) begin
         ins = mem[pcm];
         op  = ins[31:28];
         push(1, 0, pcm, 0, 0, 0, 0, ilm, rm, pcm, irm);            // fetch
         push(0, 0, 0, 0, 0, 0, 0, ilm, rm, pcm, irm);              // decode
         pcm = pcm + 12'd1;
         irm = ins;
         if (op == 4'h0) begin
            rm = rm + 16'd1;
         end else if (op == 4'h1) begin
            push(1, 0, ins[23:12], 0, 0, 0, 0, ilm, rm, pcm, irm);
            push(0, 0, 0, 1, 1, 1, 0, ilm, rm, pcm, irm);
            rm = rm + 16'd1;
         end else if (op == 4'h2) begin
            push(0, 1, ins[11:0], 0, 0, 0, 0, ilm, rm, pcm, irm);
            rm = rm + 16'd1;
         end else if (op == 4'h3) begin
            push(0, 0, 0, 0, 0, 0, 0, ilm, rm, pcm, irm);
            if (taken(ins[27:24], p)) pcm = ins[11:0];
            rm = rm + 16'd1;
         end else if (op == 4'h8 || op >= 4'hA) begin
            if (op != 4'h8) ilm = 1'b1;
            while (exp_q.size() < n)
               push(0, 0, 0, 0, 0, 0, 1, ilm, rm, pcm, irm);
         end else begin
            push(0, 0, 0, (op != 4'h9), 0, 1, 0, ilm, rm, pcm, irm);
            rm = rm + 16'd1;
         end
      end
   endtask

   // Reset, start, and compare n cycles against the model (cycle 0 is the
   // first cycle after reset is released).
   task automatic run_prog(input logic [4:0] p, input int n);
      rec_t e;
      psr = p;
      build_model(p, n);
      reset = 1'b1;
      run = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      run = 1'b1;
      for (int k = 0; k < n; k++) begin
         if (k > 0) @(negedge clk);
         e = exp_q[k];
         cap[k].rd = mem_rd; cap[k].wr = mem_wr; cap[k].addr = mem_addr;
         cap[k].rw = reg_wr; cap[k].sel = reg_wr_sel; cap[k].pw = psr_wr;
         cap[k].h = halted; cap[k].ill = illegal; cap[k].ret = retired;
         cap[k].pc = pc; cap[k].ir = ir;
         chk("mem_rd", 32'(mem_rd), 32'(e.rd));
         chk("mem_wr", 32'(mem_wr), 32'(e.wr));
         if (e.rd || e.wr) chk("mem_addr", 32'(mem_addr), 32'(e.addr));
         chk("reg_wr", 32'(reg_wr), 32'(e.rw));
         chk("psr_wr", 32'(psr_wr), 32'(e.pw));
         if (e.rw || e.pw) chk("reg_wr_sel", 32'(reg_wr_sel), 32'(e.sel));
         chk("halted", 32'(halted), 32'(e.h));
         chk("illegal", 32'(illegal), 32'(e.ill));
         chk("retired", 32'(retired), 32'(e.ret));
         chk("pc", 32'(pc), 32'(e.pc));
         chk("ir", ir, e.ir);
         chk("alu_op", 32'(alu_op), 32'(e.ir[31:28]));
      end
   endtask

   task automatic fill_halt();
      for (int i = 0; i < 4096; i++) mem[i] = 32'h8000_0000;
   endtask

   task automatic fill_random();
      logic [3:0] op;
      int r;
      for (int i = 0; i < 4096; i++) begin
         r = int'($urandom_range(0, 99));
         if (r < 3) op = 4'h8;
         else if (r < 5) op = 4'(10 + $urandom_range(0, 5));
         else begin
            op = 4'($urandom_range(0, 8));
            if (op == 4'h8) op = 4'h9;
         end
         mem[i] = {op, 4'($urandom_range(0, 15)), 12'($urandom), 12'($urandom)};
      end
   endtask

   initial begin
      fill_halt();

      // NOP then HLT
      mem[12'h100] = 32'h0000_0000;
      mem[12'h101] = 32'h8000_0000;
      run_prog(5'h00, 8);
      chk("t1_idle_retired", 32'(cap[0].ret), 32'h0);
      chk("t1_idle_pc", 32'(cap[0].pc), 32'h100);
      chk("t1_fetch0", 32'({cap[1].rd, cap[1].addr}), 32'h1100);
      chk("t1_fetch1", 32'({cap[3].rd, cap[3].addr}), 32'h1101);
      chk("t1_not_halted4", 32'(cap[4].h), 32'h0);
      chk("t1_halted5", 32'(cap[5].h), 32'h1);
      chk("t1_retired", 32'(cap[5].ret), 32'h1);
      chk("t1_pc", 32'(cap[5].pc), 32'h102);

      // LD src 200 dst r3
      mem[12'h100] = 32'h1020_0003;
      run_prog(5'h00, 8);
      chk("t2_memrd", 32'({cap[3].rd, cap[3].addr}), 32'h1200);
      chk("t2_wb", 32'({cap[4].rw, cap[4].sel, cap[4].pw}), 32'h7);
      chk("t2_next_fetch", 32'({cap[5].rd, cap[5].addr}), 32'h1101);
      chk("t2_retired", 32'(cap[5].ret), 32'h1);

      // BRA cc=5 to 300
      mem[12'h100] = 32'h3500_0300;
      mem[12'h300] = 32'h8000_0000;
      run_prog(5'h10, 8);
      chk("t3_taken", 32'({cap[4].rd, cap[4].addr}), 32'h1300);
      chk("t3_no_strobe", 32'({cap[3].rw, cap[3].pw, cap[3].rd, cap[3].wr}), 32'h0);
      run_prog(5'h0F, 8);
      chk("t3_not_taken", 32'({cap[4].rd, cap[4].addr}), 32'h1101);
      mem[12'h100] = 32'h3800_0300;
      run_prog(5'h1F, 8);
      chk("t3_cc8_never", 32'({cap[4].rd, cap[4].addr}), 32'h1101);

      // CMP then illegal opcode B
      mem[12'h100] = 32'h9000_0000;
      mem[12'h101] = 32'hB000_0000;
      run_prog(5'h00, 10);
      chk("t4_cmp", 32'({cap[3].pw, cap[3].rw}), 32'h2);
      chk("t4_halted", 32'(cap[6].h), 32'h1);
      chk("t4_illegal", 32'(cap[6].ill), 32'h1);
      chk("t4_retired", 32'(cap[6].ret), 32'h1);

      // pc wrap through NOP at FFF
      mem[12'h100] = 32'h3000_0FFF;
      mem[12'hFFF] = 32'h0000_0000;
      mem[12'h000] = 32'h8000_0000;
      run_prog(5'h00, 10);
      chk("t6_fetch_fff", 32'({cap[4].rd, cap[4].addr}), 32'h1FFF);
      chk("t6_fetch_000", 32'({cap[6].rd, cap[6].addr}), 32'h1000);
      chk("t6_pc_wrap", 32'(cap[6].pc), 32'h000);

      // Reset during MEMRD of LD abandons the instruction
      mem[12'h100] = 32'h1020_0003;
      mem[12'h101] = 32'h8000_0000;
      reset = 1'b1;
      run = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      run = 1'b1;
      repeat (3) @(negedge clk);
      chk("t5_in_memrd", 32'({mem_rd, mem_addr}), 32'h1200);
      reset = 1'b1;
      @(negedge clk);
      chk("t5_no_strobes", 32'({mem_rd, mem_wr, reg_wr, psr_wr, halted}), 32'h0);
      chk("t5_pc", 32'(pc), 32'h100);
      chk("t5_ir", ir, 32'h0);
      chk("t5_retired", 32'(retired), 32'h0);
      reset = 1'b0;
      run = 1'b0;
      @(negedge clk);
      chk("t5_idle_hold", 32'({mem_rd, reg_wr, psr_wr}), 32'h0);
      run = 1'b1;
      @(negedge clk);
      chk("t5_restart_fetch", 32'({mem_rd, mem_addr}), 32'h1100);

      // Random programs against the model
      for (int t = 0; t < 20; t++) begin
         fill_random();
         run_prog(5'($urandom), 150);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
